gamma_slice_sequencer: RTL and testbench

GAMMA_SLICE_SEQUENCER -- requirements
Module: gamma_slice_sequencer

---
 rtl/gamma_slice_sequencer.sv | 121 ++++++++++++
 tb/tb_gamma_slice_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gamma_slice_sequencer.sv
// Gamma-window sequencer: walks every (time_step, slice_sel) pair of a window,
// time-major with slices as the inner loop, then emits a one-cycle DONE bubble.
module gamma_slice_sequencer #(
    parameter int T_MAX    = 8,
    parameter int N_SLICES = 4,
    localparam int TW = (T_MAX    > 1) ? $clog2(T_MAX)    : 1,
    localparam int SW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
    input  logic          clk,
    input  logic          grst,
    input  logic          start_count,
    input  logic          stall,
    output logic [TW-1:0] time_step,
    output logic [SW-1:0] slice_sel,
    output logic          slice_valid,
    output logic          slice_last,
    output logic          gamma_done,
    output logic          busy,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TW-1:0] TS_LAST   = TW'(T_MAX - 1);
    localparam logic [SW-1:0] SS_LAST   = SW'(N_SLICES - 1);
    localparam logic          ONE_SLICE = (N_SLICES == 1);

    state_t state;

    assign fsm_state = state;

    // Valid semantics: a pair is delivered on every cycle slice_valid is high and
    // is never re-presented. A stall sampled at an edge holds the counters and
    // drops slice_valid for the following cycle; the first edge without stall
    // advances to the next pair, so a stall only inserts bubbles.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state       <= IDLE;
            time_step   <= '0;
            slice_sel   <= '0;
            slice_valid <= 1'b0;
            slice_last  <= 1'b0;
            gamma_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            gamma_done <= 1'b0;
            case (state)
                IDLE: begin
                    time_step <= '0;
                    slice_sel <= '0;
                    if (start_count) begin
                        state       <= RUN;
                        slice_valid <= 1'b1;
                        slice_last  <= ONE_SLICE;
                        busy        <= 1'b1;
                    end else begin
                        slice_valid <= 1'b0;
                        slice_last  <= 1'b0;
                        busy        <= 1'b0;
                    end
                end

                RUN: begin
                    busy <= 1'b1;
                    if (stall) begin
                        slice_valid <= 1'b0;
                        slice_last  <= 1'b0;
                    end else if (slice_sel == SS_LAST && time_step == TS_LAST) begin
                        state       <= DONE;
                        time_step   <= '0;
                        slice_sel   <= '0;
                        slice_valid <= 1'b0;
                        slice_last  <= 1'b0;
                        gamma_done  <= 1'b1;
                    end else if (slice_sel == SS_LAST) begin
                        slice_sel   <= '0;
                        time_step   <= time_step + TW'(1);
                        slice_valid <= 1'b1;
                        slice_last  <= ONE_SLICE;
                    end else begin
                        slice_sel   <= slice_sel + SW'(1);
                        slice_valid <= 1'b1;
                        slice_last  <= ((slice_sel + SW'(1)) == SS_LAST);
                    end
                end

                DONE: begin
                    time_step <= '0;
                    slice_sel <= '0;
                    // start_count is only consulted here and in IDLE, so dropping
                    // it mid-window never aborts the window in progress.
                    if (start_count) begin
                        state       <= RUN;
                        slice_valid <= 1'b1;
                        slice_last  <= ONE_SLICE;
                        busy        <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        slice_valid <= 1'b0;
                        slice_last  <= 1'b0;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    time_step   <= '0;
                    slice_sel   <= '0;
                    slice_valid <= 1'b0;
                    slice_last  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_slice_sequencer.sv
// Directed bench for gamma_slice_sequencer: default 8x4 instance plus a 5x3
// instance, outputs sampled on the falling edge against hand-derived values.
module tb_gamma_slice_sequencer;

    logic       clk = 1'b0;
    logic       grst;
    logic       start_count, stall;
    logic [2:0] time_step;
    logic [1:0] slice_sel;
    logic       slice_valid, slice_last, gamma_done, busy;
    logic [1:0] fsm_state;

    logic       start5, stall5;
    logic [2:0] time_step5;
    logic [1:0] slice_sel5;
    logic       slice_valid5, slice_last5, gamma_done5, busy5;
    logic [1:0] fsm_state5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int win_start;

    // clock / reset
    always #5 clk = ~clk;

    gamma_slice_sequencer dut (
        .clk(clk), .grst(grst), .start_count(start_count), .stall(stall),
        .time_step(time_step), .slice_sel(slice_sel), .slice_valid(slice_valid),
        .slice_last(slice_last), .gamma_done(gamma_done), .busy(busy),
        .fsm_state(fsm_state)
    );

    gamma_slice_sequencer #(.T_MAX(5), .N_SLICES(3)) dut5 (
        .clk(clk), .grst(grst), .start_count(start5), .stall(stall5),
        .time_step(time_step5), .slice_sel(slice_sel5), .slice_valid(slice_valid5),
        .slice_last(slice_last5), .gamma_done(gamma_done5), .busy(busy5),
        .fsm_state(fsm_state5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic expect_pair(input int t, input int s);
        check($sformatf("ts@%0d/%0d", t, s), 32'(time_step), 32'(t));
        check($sformatf("ss@%0d/%0d", t, s), 32'(slice_sel), 32'(s));
        check($sformatf("valid@%0d/%0d", t, s), 32'(slice_valid), 1);
        check($sformatf("last@%0d/%0d", t, s), 32'(slice_last), 32'(s == 3));
        check($sformatf("done_low@%0d/%0d", t, s), 32'(gamma_done), 0);
        check($sformatf("busy_run@%0d/%0d", t, s), 32'(busy), 1);
        check($sformatf("state_run@%0d/%0d", t, s), 32'(fsm_state), 1);
    endtask

    task automatic run_pairs(input int first, input int last_idx);
        for (int i = first; i <= last_idx; i++) begin
            expect_pair(i / 4, i % 4);
            step();
        end
    endtask

    task automatic expect_done(input int latency);
        check("done_pulse", 32'(gamma_done), 1);
        check("done_valid", 32'(slice_valid), 0);
        check("done_last", 32'(slice_last), 0);
        check("done_busy", 32'(busy), 1);
        check("done_state", 32'(fsm_state), 2);
        check("done_ts", 32'(time_step), 0);
        check("done_ss", 32'(slice_sel), 0);
        check("done_latency", 32'(cyc - win_start), 32'(latency));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_ts"}, 32'(time_step), 0);
        check({tag, "_ss"}, 32'(slice_sel), 0);
        check({tag, "_valid"}, 32'(slice_valid), 0);
        check({tag, "_last"}, 32'(slice_last), 0);
        check({tag, "_done"}, 32'(gamma_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_state"}, 32'(fsm_state), 0);
    endtask

    initial begin
        grst = 1'b1; start_count = 1'b0; stall = 1'b0; start5 = 1'b0; stall5 = 1'b0;
        step();
        step();
        expect_idle("reset");
        grst = 1'b0;
        step();
        expect_idle("idle_no_start");

        // three back-to-back windows, gamma_done every 33 cycles
        start_count = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            win_start = cyc;
            run_pairs(0, 31);
            expect_done(32);
            step();
        end

        // stall for 5 cycles at (3,2)
        win_start = cyc;
        run_pairs(0, 13);
        expect_pair(3, 2);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_ts", 32'(time_step), 3);
            check("stall_ss", 32'(slice_sel), 2);
            check("stall_valid", 32'(slice_valid), 0);
            check("stall_last", 32'(slice_last), 0);
            check("stall_busy", 32'(busy), 1);
        end
        stall = 1'b0;
        step();
        run_pairs(15, 31);
        expect_done(37);
        step();

        // drop start_count at time_step 4: window still completes
        win_start = cyc;
        run_pairs(0, 15);
        expect_pair(4, 0);
        start_count = 1'b0;
        run_pairs(16, 31);
        expect_done(32);
        step();
        expect_idle("after_drop");
        step();
        expect_idle("idle_hold");

        // asynchronous reset mid-window at (5,1)
        start_count = 1'b1;
        step();
        run_pairs(0, 20);
        expect_pair(5, 1);
        #2 grst = 1'b1;
        #1 expect_idle("async_reset");
        start_count = 1'b0;
        step();
        expect_idle("reset_held");
        grst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_idle("post_reset");
        end

        // stall ignored in IDLE; first RUN cycle one edge after start
        stall = 1'b1;
        start_count = 1'b1;
        step();
        win_start = cyc;
        expect_pair(0, 0);
        stall = 1'b0;
        start_count = 1'b0;
        step();
        run_pairs(1, 31);
        expect_done(32);
        step();
        expect_idle("after_single");

        // T_MAX=5, N_SLICES=3 instance
        start5 = 1'b1;
        step();
        start5 = 1'b0;
        for (int t = 0; t < 5; t++) begin
            for (int s = 0; s < 3; s++) begin
                check($sformatf("p5_ts@%0d/%0d", t, s), 32'(time_step5), 32'(t));
                check($sformatf("p5_ss@%0d/%0d", t, s), 32'(slice_sel5), 32'(s));
                check($sformatf("p5_valid@%0d/%0d", t, s), 32'(slice_valid5), 1);
                check($sformatf("p5_last@%0d/%0d", t, s), 32'(slice_last5), 32'(s == 2));
                check($sformatf("p5_done@%0d/%0d", t, s), 32'(gamma_done5), 0);
                step();
            end
        end
        check("p5_done_pulse", 32'(gamma_done5), 1);
        check("p5_done_valid", 32'(slice_valid5), 0);
        check("p5_done_ts", 32'(time_step5), 0);
        check("p5_done_ss", 32'(slice_sel5), 0);
        check("p5_done_busy", 32'(busy5), 1);
        step();
        check("p5_idle_busy", 32'(busy5), 0);
        check("p5_idle_state", 32'(fsm_state5), 0);
        check("p5_idle_done", 32'(gamma_done5), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
